temp_seq: RTL
=============

TEMP_SEQ -- requirements
Module: temp_seq

Interface
REQ-001 Parameter WIDTH, default 8: conversion counter and result width in bits (4..16).
REQ-002 Parameter NCH, default 2: number of sensor channels (1..4); channel 0 = PTAT, channel 1 = CTAT, others spare.
REQ-003 Parameter AVG, default 0: log2 of conversions averaged per channel (0..3).
REQ-004 Parameter TPWRUP, default 16: analog power-up settle time, in clk cycles (>=1).
REQ-005 Parameter TRST, default 4: RESET_1V8 pulse length, in clk cycles (>=1).
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle request for one pass over all channels; ignored while busy.
REQ-009 cont  in  1  level; while high, passes repeat back-to-back.
REQ-010 CMPO_1V8  in  1  asynchronous comparator output from the analog core.
REQ-011 PWRUP_1V8  out  1  analog power enable.
REQ-012 CHSEL_1V8  out  NCH  one-hot channel select; all-zero when idle.
REQ-013 RESET_1V8  out  1  integrator reset to the analog core.
REQ-014 PWM_1V8  out  1  high while counting.
REQ-015 result  out  WIDTH  averaged conversion result.
REQ-016 result_ch  out  2  channel index of result.
REQ-017 result_valid  out  1  one-cycle strobe, result/result_ch valid.
REQ-018 overflow  out  1  set with result_valid when any averaged sample saturated.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 state  out  3  encoded FSM state: IDLE=0, PWRUP=1, RST=2, COUNT=3, DONE=4.

Function
REQ-021 CMPO_1V8 SHALL pass through a 2-flop synchronizer; rising edge is detected on the synchronized value (edge flag one cycle after second flop).
REQ-022 IDLE -> PWRUP on start or cont; channel index set to 0; PWRUP_1V8 high from the PWRUP state onward.
REQ-023 PWRUP SHALL last exactly TPWRUP cycles, then -> RST.
REQ-024 RST SHALL drive RESET_1V8 high for exactly TRST cycles with CHSEL_1V8 one-hot at the current channel, then -> COUNT.
REQ-025 COUNT: counter cleared on entry, increments by 1 each cycle, PWM_1V8 high; synchronized rising edge ends the conversion and the counter value in that cycle is the sample.
REQ-026 Raw CMPO_1V8 rising before the first COUNT clock edge plus N SHALL yield sample N+2 (synchronizer latency); edges during PWRUP/RST are discarded (synchronizer still runs, edge flag masked).
REQ-027 Counter SHALL saturate: on reaching 2^WIDTH-1 without edge, conversion ends, sample = 2^WIDTH-1, overflow flag latched for the current average.
REQ-028 Samples accumulate in a WIDTH+AVG-bit accumulator; after 2^AVG conversions of one channel (each with its own RST phase) -> DONE.
REQ-029 DONE lasts one cycle: result = accumulator >> AVG (truncating), result_ch = channel, overflow = latched flag, result_valid = 1; accumulator and flag cleared.
REQ-030 After DONE: if channel < NCH-1, channel+1 and -> RST; else if cont high, channel wraps to 0 and -> RST (no PWRUP re-wait); else -> IDLE, PWRUP_1V8 low, CHSEL_1V8 zero.
REQ-031 cont falling mid-pass SHALL complete the current pass, then IDLE; start during busy SHALL be ignored, not queued.
REQ-032 Simultaneous CMPO edge and counter saturation in the same cycle SHALL be treated as edge (sample = 2^WIDTH-1, overflow not set).
REQ-033 result, result_ch, overflow SHALL hold their value until the next DONE.

Reset
REQ-034 reset low SHALL immediately force state IDLE, all outputs 0, counter, accumulator, channel, synchronizer and flags to 0, including mid-conversion; no result_valid is emitted for an aborted pass.
REQ-035 After reset release, the block SHALL wait for a new start or cont.

Verification
REQ-036 Defaults, start pulse, CMPO rising at COUNT+50 on ch0 and COUNT+120 on ch1 -> result 52 ch0, result 122 ch1, two result_valid strobes, then IDLE, PWRUP_1V8 low.
REQ-037 CMPO held low through COUNT -> result 255, overflow 1, busy drops after ch1.
REQ-038 AVG=2, ch0 samples 10,11,12,14 -> result 11, exactly one result_valid for ch0, four RESET_1V8 pulses of TRST cycles.
REQ-039 cont high for 2.5 passes -> channel sequence 0,1,0,1,0,1 with no PWRUP state between passes, IDLE after the third pass.
REQ-040 reset asserted during COUNT of ch1 -> all outputs 0 within same cycle, no result_valid; fresh start gives correct ch0 result.
REQ-041 start pulses during busy and CMPO glitches in RST -> no extra passes, samples unaffected.

Source files
------------

// File: rtl/temp_seq_if.sv
// Control/result bus of the temperature sequencer: pass requests in, averaged
// results and FSM status out.
interface temp_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             cont;
  logic [WIDTH-1:0] result;
  logic [1:0]       result_ch;
  logic             result_valid;
  logic             overflow;
  logic             busy;
  logic [2:0]       state;

  // Requester side (system controller / testbench)
  modport master (
    output start, cont,
    input  result, result_ch, result_valid, overflow, busy, state
  );

  // Sequencer side
  modport slave (
    input  start, cont,
    output result, result_ch, result_valid, overflow, busy, state
  );
endinterface

// File: rtl/temp_seq.sv
// Temperature sensor sequencer: powers up the analog core, then for each
// channel runs 2^AVG integrate-and-count conversions (reset pulse, counter
// running until the comparator fires or the counter saturates), averages
// them and strobes one result per channel.
module temp_seq #(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int AVG    = 0,
  parameter int TPWRUP = 16,
  parameter int TRST   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           CMPO_1V8,
  output logic           PWRUP_1V8,
  output logic [NCH-1:0] CHSEL_1V8,
  output logic           RESET_1V8,
  output logic           PWM_1V8,
  temp_seq_if.slave      bus
);

  localparam int TMAX  = (TPWRUP > TRST) ? TPWRUP : TRST;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int ACC_W = WIDTH + AVG;
  localparam logic [AVG:0] NCONV_LAST = (AVG + 1)'((1 << AVG) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PWRUP = 3'd1,
    S_RST   = 3'd2,
    S_COUNT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [1:0]       ch_q, ch_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [AVG:0]     nconv_q, nconv_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       res_ch_q, res_ch_d;
  logic             res_ovf_q, res_ovf_d;
  // [0],[1]: two-flop synchronizer; [2]: previous synchronized value
  logic [2:0]       sync_q, sync_d;

  logic             cmp_rise;
  logic             cnt_max;
  logic             conv_end;
  logic             sat;
  logic             last_conv;
  logic [ACC_W-1:0] sum;

  // Conversion bookkeeping shared by next-state and datapath logic
  always_comb begin
    cmp_rise  = sync_q[1] & ~sync_q[2];
    cnt_max   = (cnt_q == {WIDTH{1'b1}});
    // an edge landing on the saturation cycle wins: no overflow
    conv_end  = (state_q == S_COUNT) && (cmp_rise || cnt_max);
    sat       = cnt_max && !cmp_rise;
    last_conv = (nconv_q == NCONV_LAST);
    sum       = acc_q + ACC_W'(cnt_q);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      nconv_q   <= '0;
      ovf_acc_q <= 1'b0;
      res_q     <= '0;
      res_ch_q  <= '0;
      res_ovf_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      nconv_q   <= nconv_d;
      ovf_acc_q <= ovf_acc_d;
      res_q     <= res_d;
      res_ch_q  <= res_ch_d;
      res_ovf_q <= res_ovf_d;
      sync_q    <= sync_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start || bus.cont) state_d = S_PWRUP;
      S_PWRUP: if (tmr_q == TW'(TPWRUP - 1)) state_d = S_RST;
      S_RST:   if (tmr_q == TW'(TRST - 1)) state_d = S_COUNT;
      S_COUNT: if (conv_end) state_d = last_conv ? S_DONE : S_RST;
      S_DONE: begin
        // next channel, or wrap straight to RST while cont holds the core up
        if (ch_q < 2'(NCH - 1) || bus.cont) state_d = S_RST;
        else                                state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: phase timer, conversion counter, accumulator, result registers
  always_comb begin
    sync_d    = {sync_q[1:0], CMPO_1V8};
    tmr_d     = '0;
    ch_d      = ch_q;
    cnt_d     = '0;
    acc_d     = acc_q;
    nconv_d   = nconv_q;
    ovf_acc_d = ovf_acc_q;
    res_d     = res_q;
    res_ch_d  = res_ch_q;
    res_ovf_d = res_ovf_q;

    // timer restarts on every phase change
    if ((state_q == S_PWRUP || state_q == S_RST) && state_d == state_q)
      tmr_d = tmr_q + 1'b1;

    if (state_q == S_IDLE && state_d == S_PWRUP)
      ch_d = '0;

    if (state_q == S_COUNT && !conv_end)
      cnt_d = cnt_q + 1'b1;

    if (conv_end) begin
      if (last_conv) begin
        res_d     = WIDTH'(sum >> AVG);
        res_ch_d  = ch_q;
        res_ovf_d = ovf_acc_q | sat;
        acc_d     = '0;
        ovf_acc_d = 1'b0;
        nconv_d   = '0;
      end else begin
        acc_d     = sum;
        ovf_acc_d = ovf_acc_q | sat;
        nconv_d   = nconv_q + 1'b1;
      end
    end

    if (state_q == S_DONE)
      ch_d = (ch_q < 2'(NCH - 1)) ? ch_q + 2'd1 : 2'd0;
  end

  // Outputs decoded from the current state
  always_comb begin
    PWRUP_1V8 = (state_q != S_IDLE);
    RESET_1V8 = (state_q == S_RST);
    PWM_1V8   = (state_q == S_COUNT);
    CHSEL_1V8 = '0;
    if (state_q == S_RST || state_q == S_COUNT || state_q == S_DONE)
      for (int i = 0; i < NCH; i++) CHSEL_1V8[i] = (ch_q == 2'(i));
  end

  assign bus.result       = res_q;
  assign bus.result_ch    = res_ch_q;
  assign bus.overflow     = res_ovf_q;
  assign bus.result_valid = (state_q == S_DONE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.state        = state_q;

endmodule
